// File: rtl/gol_pkg.sv
// Shared Game-of-Life types and grid geometry, used by the cell array, this
// scanner and the VGA top.
package gol_pkg;

    localparam int GRIDWIDTH  = 32;
    localparam int GRIDHEIGHT = 24;
    localparam int CELL_PX    = 20;

    typedef enum logic [1:0] {
        COAL_NONE,
        COAL_RED,
        COAL_GREEN,
        COAL_BLUE
    } coalition_e;

    typedef enum logic [1:0] {
        COND_DEAD,
        COND_BORN,
        COND_ALIVE,
        COND_DYING
    } condition_e;

    typedef struct packed {
        logic       alive;
        coalition_e coalition;
        condition_e condition;
    } entity_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

endpackage

// File: rtl/cell_frame_scanner_if.sv
// Pixel-timing, generation-capture and colour bundle between the sync
// generator / cell array side and the frame scanner.
interface cell_frame_scanner_if #(
    parameter int GW = gol_pkg::GRIDWIDTH,
    parameter int GH = gol_pkg::GRIDHEIGHT
);
    logic             pixel_en;
    logic             hblank_n;
    logic             vblank_n;
    logic [GH*GW-1:0] cell_alive;
    logic             gen_valid;
    logic [3:0]       vga_r;
    logic [3:0]       vga_g;
    logic [3:0]       vga_b;
    logic             frame_start;
    logic             pending;

    modport master (
        output pixel_en, hblank_n, vblank_n, cell_alive, gen_valid,
        input  vga_r, vga_g, vga_b, frame_start, pending
    );

    modport slave (
        input  pixel_en, hblank_n, vblank_n, cell_alive, gen_valid,
        output vga_r, vga_g, vga_b, frame_start, pending
    );
endinterface

// File: rtl/tile_counter.sv
// Sub-tile pixel counter feeding a saturating cell index; one instance walks
// columns along a line, another walks rows down the frame.
module tile_counter #(
    parameter int CELLS = 32,
    parameter int SUB   = 20,
    localparam int IW   = $clog2(CELLS),
    localparam int SW   = $clog2(SUB)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [SW-1:0] sub,
    output logic [IW-1:0] idx
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub <= '0;
            idx <= '0;
        end else if (clr) begin
            sub <= '0;
            idx <= '0;
        end else if (step) begin
            if (sub == SW'(SUB - 1)) begin
                sub <= '0;
                // Overscan keeps repeating the last cell instead of wrapping
                if (idx != IW'(CELLS - 1))
                    idx <= idx + 1'b1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cell_frame_scanner.sv
// Double-buffered grid snapshot plus counter-driven tile walk; emits registered
// RGB two pixel strobes behind the blanking inputs.
module cell_frame_scanner
    import gol_pkg::rgb_t;
#(
    parameter int          GRIDWIDTH  = gol_pkg::GRIDWIDTH,
    parameter int          GRIDHEIGHT = gol_pkg::GRIDHEIGHT,
    parameter int          CELL_PX    = gol_pkg::CELL_PX,
    parameter int          SHOW_GRID  = 0,
    parameter logic [11:0] LIVE_RGB   = 12'h000,
    parameter logic [11:0] DEAD_RGB   = 12'hFFF,
    parameter logic [11:0] GRID_RGB   = 12'h888
) (
    input logic               clk,
    input logic               rst,
    cell_frame_scanner_if.slave bus
);

    localparam int N  = GRIDWIDTH * GRIDHEIGHT;
    localparam int NW = $clog2(N);
    localparam int CW = $clog2(GRIDWIDTH);
    localparam int RW = $clog2(GRIDHEIGHT);
    localparam int SW = $clog2(CELL_PX);

    logic [N-1:0]  pend_buf, disp_buf, disp_nxt;
    logic          pend_q, vb_q, hb_q;
    logic          swap, h_fall, visible;
    logic [SW-1:0] px_sub, ln_sub;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [NW-1:0] cell_idx;
    logic          bit_q, border_q, vis1;
    rgb_t          rgb_q;

    assign visible = bus.hblank_n & bus.vblank_n;
    assign swap    = bus.pixel_en & ~vb_q & bus.vblank_n;
    assign h_fall  = bus.pixel_en & bus.vblank_n & hb_q & ~bus.hblank_n;

    // The first pixel of a new frame must already see the swapped buffer
    always_comb begin
        disp_nxt = disp_buf;
        if (swap) begin
            if (bus.gen_valid)
                disp_nxt = bus.cell_alive;
            else if (pend_q)
                disp_nxt = pend_buf;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_buf <= '0;
            disp_buf <= '0;
            pend_q   <= 1'b0;
            vb_q     <= 1'b1;
            hb_q     <= 1'b1;
        end else begin
            disp_buf <= disp_nxt;
            if (bus.gen_valid)
                pend_buf <= bus.cell_alive;
            pend_q <= swap ? 1'b0 : (pend_q | bus.gen_valid);
            if (bus.pixel_en) begin
                vb_q <= bus.vblank_n;
                hb_q <= bus.hblank_n;
            end
        end
    end

    tile_counter #(.CELLS(GRIDWIDTH), .SUB(CELL_PX)) u_horiz (
        .clk  (clk),
        .rst  (rst),
        .clr  ((bus.pixel_en & ~bus.vblank_n) | h_fall),
        .step (bus.pixel_en & visible),
        .sub  (px_sub),
        .idx  (col)
    );

    tile_counter #(.CELLS(GRIDHEIGHT), .SUB(CELL_PX)) u_vert (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.pixel_en & ~bus.vblank_n),
        .step (h_fall),
        .sub  (ln_sub),
        .idx  (row)
    );

    assign cell_idx = NW'(row) * NW'(GRIDWIDTH) + NW'(col);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q    <= 1'b0;
            border_q <= 1'b0;
            vis1     <= 1'b0;
            rgb_q    <= '0;
        end else if (bus.pixel_en) begin
            bit_q    <= disp_nxt[cell_idx];
            border_q <= (SHOW_GRID != 0) && (px_sub == '0 || ln_sub == '0);
            vis1     <= visible;
            if (!vis1)
                rgb_q <= '0;
            else if (border_q)
                rgb_q <= GRID_RGB;
            else if (bit_q)
                rgb_q <= LIVE_RGB;
            else
                rgb_q <= DEAD_RGB;
        end
    end

    assign bus.vga_r       = rgb_q.r;
    assign bus.vga_g       = rgb_q.g;
    assign bus.vga_b       = rgb_q.b;
    assign bus.frame_start = swap;
    assign bus.pending     = pend_q;

endmodule

// File: tb/tb_cell_frame_scanner.sv
// Directed bench for cell_frame_scanner on a 4x3 grid of 20-pixel tiles, with
// a second instance drawing the grid overlay.
module tb_cell_frame_scanner;

    localparam int GW = 4;
    localparam int GH = 3;
    localparam int N  = GW * GH;
    localparam int H  = 60;
    localparam int WMAX = 90;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         pixel_en = 1'b0;
    logic         hblank_n = 1'b0;
    logic         vblank_n = 1'b0;
    logic         gen_valid = 1'b0;
    logic [N-1:0] cell_alive = '0;

    always #5 clk = ~clk;

    cell_frame_scanner_if #(.GW(GW), .GH(GH)) b0 ();
    cell_frame_scanner_if #(.GW(GW), .GH(GH)) bg ();

    assign b0.pixel_en = pixel_en;   assign bg.pixel_en = pixel_en;
    assign b0.hblank_n = hblank_n;   assign bg.hblank_n = hblank_n;
    assign b0.vblank_n = vblank_n;   assign bg.vblank_n = vblank_n;
    assign b0.gen_valid = gen_valid; assign bg.gen_valid = gen_valid;
    assign b0.cell_alive = cell_alive;
    assign bg.cell_alive = cell_alive;

    cell_frame_scanner #(.GRIDWIDTH(GW), .GRIDHEIGHT(GH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    cell_frame_scanner #(.GRIDWIDTH(GW), .GRIDHEIGHT(GH), .SHOW_GRID(1)) dut_g (
        .clk (clk),
        .rst (rst),
        .bus (bg.slave)
    );

    wire [11:0] rgb0 = {b0.vga_r, b0.vga_g, b0.vga_b};
    wire [11:0] rgbg = {bg.vga_r, bg.vga_g, bg.vga_b};

    logic [11:0] frm   [0:H-1][0:WMAX-1];
    logic [11:0] frm_g [0:H-1][0:WMAX-1];
    logic [11:0] vb_rgb;
    logic        pend_sw;
    int          passed = 0;
    int          total = 0;
    int          fs_cnt = 0;
    int          fs0;

    always @(posedge clk) if (b0.frame_start) fs_cnt <= fs_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One pixel strobe; returns at the falling edge after the strobe's edge
    task automatic strobe(input bit hb, input bit vb, input bit g);
        @(negedge clk);
        hblank_n = hb; vblank_n = vb; gen_valid = g; pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0; gen_valid = 1'b0;
    endtask

    task automatic gen(input logic [N-1:0] pat);
        cell_alive = pat; gen_valid = 1'b1;
        @(negedge clk);
        gen_valid = 1'b0;
    endtask

    // Two vblank lines, then nl visible lines of w pixels plus 4 blank pixels
    task automatic frame(input int nl, input int w, input int gy,
                         input logic [N-1:0] gpat, input bit sg, input logic [N-1:0] spat);
        for (int l = 0; l < 2; l++) begin
            for (int x = 0; x < w; x++) strobe(1'b1, 1'b0, 1'b0);
            for (int x = 0; x < 4; x++) strobe(1'b0, 1'b0, 1'b0);
            if (l == 0) vb_rgb = rgb0;
        end
        fs0 = fs_cnt;
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < w; x++) begin
                if (y == 0 && x == 0 && sg) cell_alive = spat;
                strobe(1'b1, 1'b1, (y == 0 && x == 0 && sg));
                if (y == 0 && x == 0) pend_sw = b0.pending;
                if (x > 0) begin
                    frm[y][x-1]   = rgb0;
                    frm_g[y][x-1] = rgbg;
                end
                if (y == gy && x == 40) gen(gpat);
            end
            for (int x = 0; x < 4; x++) begin
                strobe(1'b0, 1'b1, 1'b0);
                if (x == 0) begin
                    frm[y][w-1]   = rgb0;
                    frm_g[y][w-1] = rgbg;
                end
            end
        end
    endtask

    initial begin
        // Reset state and pipeline refill
        @(negedge clk);
        chk("rst_rgb", 32'(rgb0), 32'h0);
        chk("rst_pending", 32'(b0.pending), 32'h0);
        chk("rst_frame_start", 32'(b0.frame_start), 32'h0);
        rst = 1'b0;
        strobe(1'b1, 1'b1, 1'b0);
        chk("refill_black", 32'(rgb0), 32'h0);
        strobe(1'b1, 1'b1, 1'b0);
        chk("first_px_dead", 32'(rgb0), 32'hFFF);
        gen(12'h001);
        chk("capture_pending", 32'(b0.pending), 32'h1);
        for (int i = 0; i < 3; i++) strobe(1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a line
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rgb", 32'(rgb0), 32'h0);
        chk("midrst_pending", 32'(b0.pending), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        strobe(1'b1, 1'b1, 1'b0);
        chk("midrst_refill", 32'(rgb0), 32'h0);
        strobe(1'b1, 1'b1, 1'b0);
        chk("midrst_first_px", 32'(rgb0), 32'hFFF);
        for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, 1'b0);
        chk("no_swap_yet", 32'(fs_cnt), 32'd0);

        // F1: nothing pending, grid overlay, capture cell (0,0) mid-frame
        frame(25, 80, 5, 12'h001, 1'b0, '0);
        chk("f1_frame_start", 32'(fs_cnt - fs0), 32'd1);
        chk("f1_pend_at_swap", 32'(pend_sw), 32'h0);
        chk("f1_px0_0", 32'(frm[0][0]), 32'hFFF);
        chk("f1_after_capture", 32'(frm[10][5]), 32'hFFF);
        chk("f1_pending", 32'(b0.pending), 32'h1);
        chk("grid_x0", 32'(frm_g[5][0]), 32'h888);
        chk("grid_x20", 32'(frm_g[5][20]), 32'h888);
        chk("grid_x40", 32'(frm_g[5][40]), 32'h888);
        chk("grid_y0", 32'(frm_g[0][5]), 32'h888);
        chk("grid_y20", 32'(frm_g[20][5]), 32'h888);
        chk("grid_inner", 32'(frm_g[1][1]), 32'hFFF);

        // F2: captured (0,0) appears; a new capture must not tear this frame
        frame(25, 80, 10, 12'h800, 1'b0, '0);
        chk("f2_frame_start", 32'(fs_cnt - fs0), 32'd1);
        chk("f2_pend_cleared", 32'(pend_sw), 32'h0);
        chk("f2_x0y0", 32'(frm[0][0]), 32'h000);
        chk("f2_x19y19", 32'(frm[19][19]), 32'h000);
        chk("f2_x20y0", 32'(frm[0][20]), 32'hFFF);
        chk("f2_x0y20", 32'(frm[20][0]), 32'hFFF);
        chk("f2_tear_free", 32'(frm[15][0]), 32'h000);
        chk("f2_pending", 32'(b0.pending), 32'h1);

        // F3: last tile (row 2, col 3) with 90-pixel overscan lines
        frame(60, 90, 10, 12'h020, 1'b0, '0);
        chk("vblank_black", 32'(vb_rgb), 32'h0);
        chk("f3_first_live", 32'(frm[40][60]), 32'h000);
        chk("f3_last_live", 32'(frm[59][79]), 32'h000);
        chk("f3_above_tile", 32'(frm[39][60]), 32'hFFF);
        chk("f3_left_tile", 32'(frm[40][59]), 32'hFFF);
        chk("f3_origin", 32'(frm[0][0]), 32'hFFF);
        chk("overrun_repeat", 32'(frm[45][85]), 32'h000);
        chk("overrun_end", 32'(frm[59][89]), 32'h000);
        chk("overrun_row1", 32'(frm[30][85]), 32'hFFF);
        chk("next_line_col0", 32'(frm[41][0]), 32'hFFF);

        // F4: generation arrives on the swap strobe and beats the pending one
        frame(25, 80, -1, '0, 1'b1, 12'h002);
        chk("f4_frame_start", 32'(fs_cnt - fs0), 32'd1);
        chk("f4_pend_cleared", 32'(pend_sw), 32'h0);
        chk("coinc_b_x20", 32'(frm[0][20]), 32'h000);
        chk("coinc_b_x39y19", 32'(frm[19][39]), 32'h000);
        chk("coinc_not_a", 32'(frm[20][20]), 32'hFFF);
        chk("coinc_origin", 32'(frm[0][0]), 32'hFFF);
        chk("f4_pending", 32'(b0.pending), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
